// File: rtl/tick_gen_pkg.sv
// Shared types for the multi-channel tick generator.
package tick_gen_pkg;

   typedef enum logic [1:0] {
      CH_OFF  = 2'd0,
      CH_IDLE = 2'd1,
      CH_RUN  = 2'd2
   } ch_state_t;

   localparam logic MODE_PERIODIC = 1'b0;
   localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: OFF/IDLE/RUN state machine, divisor register, counter,
// registered tick / square-wave / busy outputs.
module tick_chan
   import tick_gen_pkg::*;
#(
   parameter int          DIV_W   = 26,
   parameter int unsigned DIV_RST = 25000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             start,
   input  logic             we,
   input  logic [DIV_W-1:0] div_in,
   output logic             tick,
   output logic             sq,
   output logic             busy
);

   ch_state_t        r_state, w_state_nxt;
   logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
   logic [DIV_W-1:0] r_div, w_div_nxt;
   logic             r_tick, w_tick_nxt;
   logic             r_sq, w_sq_nxt;
   logic             r_busy, w_busy_nxt;
   logic             w_wrap, w_retrig;

   assign w_wrap   = (r_state == CH_RUN) && (r_cnt == r_div - DIV_W'(1));
   // A one-shot restart aborts the current period, even on its last cycle.
   assign w_retrig = (r_state == CH_RUN) && start && (mode == MODE_ONESHOT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= CH_OFF;
         r_cnt   <= '0;
         r_div   <= DIV_W'(DIV_RST);
         r_tick  <= 1'b0;
         r_sq    <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_div   <= w_div_nxt;
         r_tick  <= w_tick_nxt;
         r_sq    <= w_sq_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!en) begin
         w_state_nxt = CH_OFF;
      end else begin
         case (r_state)
            CH_OFF:  w_state_nxt = (mode == MODE_ONESHOT) ? CH_IDLE : CH_RUN;
            CH_IDLE: if (mode == MODE_PERIODIC || start) w_state_nxt = CH_RUN;
            CH_RUN:  if (w_wrap && !w_retrig && mode == MODE_ONESHOT) w_state_nxt = CH_IDLE;
            default: w_state_nxt = CH_OFF;
         endcase
      end
   end

   always_comb begin
      w_div_nxt  = r_div;
      w_cnt_nxt  = '0;
      w_tick_nxt = 1'b0;
      w_sq_nxt   = r_sq;
      w_busy_nxt = en && (r_state == CH_RUN);
      if (we) w_div_nxt = (div_in == '0) ? DIV_W'(1) : div_in;
      if (!en) begin
         w_sq_nxt = 1'b0;
      end else if (r_state == CH_RUN && !w_retrig) begin
         if (w_wrap) begin
            w_tick_nxt = 1'b1;
            w_sq_nxt   = ~r_sq;
         end else if (!we) begin
            w_cnt_nxt  = r_cnt + DIV_W'(1);
         end
      end
   end

   assign tick = r_tick;
   assign sq   = r_sq;
   assign busy = r_busy;

endmodule

// File: rtl/tick_gen_mc.sv
// Multi-channel clock-enable generator: N_CH independent tick channels sharing
// one divisor-write port.
module tick_gen_mc
   import tick_gen_pkg::*;
#(
   parameter int          N_CH    = 4,
   parameter int          DIV_W   = 26,
   parameter int unsigned DIV_RST = 25000,
   localparam int         CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_CH-1:0]  ch_en,
   input  logic [N_CH-1:0]  ch_mode,
   input  logic [N_CH-1:0]  start,
   input  logic             cfg_we,
   input  logic [CH_W-1:0]  cfg_ch,
   input  logic [DIV_W-1:0] cfg_div,
   output logic [N_CH-1:0]  tick,
   output logic [N_CH-1:0]  sq,
   output logic [N_CH-1:0]  busy
);

   logic [N_CH-1:0] w_we;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      // Out-of-range channel numbers match no instance and are dropped.
      assign w_we[i] = cfg_we && (cfg_ch == CH_W'(i));

      tick_chan #(
         .DIV_W   (DIV_W),
         .DIV_RST (DIV_RST)
      ) u_chan (
         .clk    (clk),
         .rst    (rst),
         .en     (ch_en[i]),
         .mode   (ch_mode[i]),
         .start  (start[i]),
         .we     (w_we[i]),
         .div_in (cfg_div),
         .tick   (tick[i]),
         .sq     (sq[i]),
         .busy   (busy[i])
      );
   end

endmodule

// File: tb/tb_tick_gen_mc.sv
// Bench for tick_gen_mc: table vectors, hand-written corner sequences and
// random traffic against a deadline-based reference model.
module tb_tick_gen_mc;

   localparam int N    = 5;
   localparam int DW   = 8;
   localparam int DRST = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [N-1:0]  ch_en = '0, ch_mode = '0, start = '0;
   logic          cfg_we = 1'b0;
   logic [2:0]    cfg_ch = '0;
   logic [DW-1:0] cfg_div = '0;
   logic [N-1:0]  tick, sq, busy;

   int n_vec = 0;
   int n_err = 0;
   int n_edge = 0;

   // reference model: channel on/counting flags plus the edge number of the next tick
   bit   [N-1:0] m_on, m_run;
   int           m_deadline[N];
   int           m_div[N];
   logic [N-1:0] m_tick, m_sq, m_busy;

   typedef struct {
      logic [N-1:0] en;
      logic [N-1:0] mode;
      logic [N-1:0] exp_tick;
      logic [N-1:0] exp_sq;
      logic [N-1:0] exp_busy;
   } vec_t;
   vec_t tbl[14];

   tick_gen_mc #(.N_CH(N), .DIV_W(DW), .DIV_RST(DRST)) dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .ch_mode(ch_mode), .start(start),
      .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
      .tick(tick), .sq(sq), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, n_edge);
      end
   endtask

   task automatic model_reset();
      m_on = '0; m_run = '0; m_tick = '0; m_sq = '0; m_busy = '0;
      for (int c = 0; c < N; c++) begin
         m_div[c] = DRST;
         m_deadline[c] = 0;
      end
   endtask

   task automatic model_edge();
      logic [N-1:0] t_n, s_n, b_n;
      int dv;
      bit wr;
      n_edge++;
      if (!rst) begin
         model_reset();
         return;
      end
      for (int c = 0; c < N; c++) begin
         wr = cfg_we && (int'(cfg_ch) == c);
         dv = wr ? ((cfg_div == 0) ? 1 : int'(cfg_div)) : m_div[c];
         b_n[c] = ch_en[c] && m_run[c];
         t_n[c] = 1'b0;
         s_n[c] = m_sq[c];
         if (!ch_en[c]) begin
            m_on[c] = 1'b0; m_run[c] = 1'b0; s_n[c] = 1'b0;
         end else if (!m_on[c]) begin
            m_on[c] = 1'b1;
            m_run[c] = !ch_mode[c];
            m_deadline[c] = n_edge + dv;
         end else if (!m_run[c]) begin
            if (!ch_mode[c] || start[c]) begin
               m_run[c] = 1'b1;
               m_deadline[c] = n_edge + dv;
            end
         end else if (start[c] && ch_mode[c]) begin
            m_deadline[c] = n_edge + dv;
         end else if (n_edge == m_deadline[c]) begin
            t_n[c] = 1'b1;
            s_n[c] = ~m_sq[c];
            if (ch_mode[c]) m_run[c] = 1'b0;
            else m_deadline[c] = n_edge + dv;
         end else if (wr) begin
            m_deadline[c] = n_edge + dv;
         end
         m_div[c] = dv;
      end
      m_tick = t_n; m_sq = s_n; m_busy = b_n;
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("tick", tick, m_tick);
      chk("sq", sq, m_sq);
      chk("busy", busy, m_busy);
   endtask

   initial begin
      int first;
      bit seen;
      logic sq_exp;

      tbl[0]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00000};
      tbl[1]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[2]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[3]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[4]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b1, exp_sq:5'b1, exp_busy:5'b00001};
      tbl[5]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b1, exp_busy:5'b00001};
      tbl[6]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b1, exp_busy:5'b00001};
      tbl[7]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b1, exp_busy:5'b00001};
      tbl[8]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b1, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[9]  = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[10] = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[11] = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b0, exp_busy:5'b00001};
      tbl[12] = '{en:5'b00001, mode:5'b0, exp_tick:5'b1, exp_sq:5'b1, exp_busy:5'b00001};
      tbl[13] = '{en:5'b00001, mode:5'b0, exp_tick:5'b0, exp_sq:5'b1, exp_busy:5'b00001};

      // clock / reset
      model_reset();
      cyc(); cyc();
      chk("rst_tick", tick, 0);
      chk("rst_sq", sq, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b1;

      // periodic channel 0, reset divisor 4
      for (int i = 0; i < 14; i++) begin
         ch_en = tbl[i].en;
         ch_mode = tbl[i].mode;
         cyc();
         chk("tbl_tick", tick, tbl[i].exp_tick);
         chk("tbl_sq", sq, tbl[i].exp_sq);
         chk("tbl_busy", busy, tbl[i].exp_busy);
      end

      // divisor write to ch0 when its counter is at 2
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         cyc();
         if (tick[0]) seen = 1'b1;
      end
      chk("t0_seen", 32'(seen), 1);
      cyc(); cyc();
      cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 8'd10;
      sq_exp = m_sq[0];
      cyc();
      cfg_we = 1'b0;
      chk("wr_sq_keep", 32'(sq[0]), 32'(sq_exp));
      first = -1;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         if (tick[0] && first < 0) first = k;
      end
      chk("wr_next_tick", first, 10);

      // one-shot ch1, div 3
      cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 8'd3;
      cyc();
      cfg_we = 1'b0;
      ch_en[1] = 1'b1; ch_mode[1] = 1'b1;
      cyc(); cyc();
      chk("os_idle_busy", 32'(busy[1]), 0);
      start[1] = 1'b1; cyc(); start[1] = 1'b0;
      chk("os_b0", 32'(busy[1]), 0);
      cyc(); chk("os_b1", 32'(busy[1]), 1); chk("os_t1", 32'(tick[1]), 0);
      cyc(); chk("os_b2", 32'(busy[1]), 1); chk("os_t2", 32'(tick[1]), 0);
      cyc(); chk("os_b3", 32'(busy[1]), 1); chk("os_t3", 32'(tick[1]), 1);
      cyc(); chk("os_b4", 32'(busy[1]), 0); chk("os_t4", 32'(tick[1]), 0);
      cyc(); chk("os_b5", 32'(busy[1]), 0);
      // retrigger two cycles after start
      start[1] = 1'b1; cyc(); start[1] = 1'b0;
      cyc();
      start[1] = 1'b1; cyc(); start[1] = 1'b0;
      cyc(); chk("rt_t3", 32'(tick[1]), 0);
      cyc(); chk("rt_t4", 32'(tick[1]), 0);
      cyc(); chk("rt_t5", 32'(tick[1]), 1);
      cyc(); chk("rt_b6", 32'(busy[1]), 0);

      // divisor 0 on ch2 ticks every cycle; out-of-range write is dropped
      cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 8'd0;
      cyc();
      cfg_we = 1'b0;
      ch_en[2] = 1'b1; ch_mode[2] = 1'b0;
      cyc();
      for (int k = 0; k < 6; k++) begin
         cyc(); chk("div1_tick", 32'(tick[2]), 1);
      end
      cfg_we = 1'b1; cfg_ch = 3'(N); cfg_div = 8'd7;
      cyc();
      cfg_we = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(); chk("badch_tick", 32'(tick[2]), 1);
      end

      // drop ch3 enable on the edge its second tick would register
      ch_en[3] = 1'b1; ch_mode[3] = 1'b0;
      cyc();
      for (int k = 0; k < 4; k++) cyc();
      chk("c3_tick", 32'(tick[3]), 1);
      chk("c3_sq", 32'(sq[3]), 1);
      for (int k = 0; k < 3; k++) cyc();
      ch_en[3] = 1'b0;
      cyc();
      chk("off_tick", 32'(tick[3]), 0);
      chk("off_sq", 32'(sq[3]), 0);
      chk("off_busy", 32'(busy[3]), 0);

      // random traffic against the model
      ch_en = '1;
      ch_mode = N'($urandom);
      for (int k = 0; k < 500; k++) begin
         if ($urandom_range(0, 15) == 0) ch_en[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 31) == 0) ch_mode[$urandom_range(0, N-1)] ^= 1'b1;
         start = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         cfg_we = ($urandom_range(0, 9) == 0);
         cfg_ch = 3'($urandom_range(0, 7));
         cfg_div = ($urandom_range(0, 40) == 0) ? 8'hFF : 8'($urandom_range(0, 12));
         cyc();
      end
      start = '0; cfg_we = 1'b0;

      // asynchronous reset mid-run
      ch_en = '1; ch_mode = '0;
      for (int k = 0; k < 6; k++) cyc();
      #2 rst = 1'b0;
      #1;
      chk("arst_tick", tick, 0);
      chk("arst_sq", sq, 0);
      chk("arst_busy", busy, 0);
      model_reset();
      cyc(); cyc();
      rst = 1'b1;
      cyc();
      for (int k = 0; k < 3; k++) cyc();
      cyc();
      chk("rst_div_tick", tick, 5'b11111);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
